mac_accum_tree: RTL
===================

Name: mac_accum_tree

Overview:
- Parametrised successor to the fixed 256-lane binary-activation MAC with its registered 8-level adder tree.
- N_LANES 1-bit activations gate N_LANES unsigned W_BITS weights; products are reduced in a fully pipelined tree.
- Tree sums are accumulated across multi-beat frames delimited by in_last, so dot products longer than N_LANES finish in one result Q.
- Sits between the activation/weight feeders and the downstream result consumer.

Parameters:
N_LANES, 256, lane count; power of 2, >= 2
W_BITS, 4, unsigned weight width per lane
ACC_W, 20, accumulator/Q width; must be >= SUM_W
CNT_W, 16, beat-counter width
Derived (localparam): LVL = log2(N_LANES); SUM_W = W_BITS + LVL (12 at defaults)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  beat qualifier; no backpressure, a beat is accepted every cycle it is high
in_last  input  1  final beat of frame; sampled only when in_valid=1
in_array  input  N_LANES  activation bits, lane i = bit i
weight_array  input  N_LANES*W_BITS  lane i weight = bits [i*W_BITS +: W_BITS]
sum_valid  output  1  one-cycle pulse per beat leaving the tree
total_sum  output  SUM_W  per-beat tree sum, valid with sum_valid
out_valid  output  1  one-cycle pulse when a frame result is ready
Q  output  ACC_W  frame accumulation result, held until next out_valid
beat_cnt  output  CNT_W  beats in the frame reported by the latest out_valid
ovf  output  1  sticky; set if any frame accumulation exceeded 2^ACC_W-1

Behaviour:
- Reset: every pipeline valid bit, total_sum, Q, beat_cnt, ovf, out_valid, sum_valid and accumulator are cleared to 0 on the first clock with reset=1. The frame-start flag is set. In-flight beats are discarded and never produce sum_valid or out_valid.
- Product stage is combinational: p_i = in_array[i] ? w_i : 0.
- Tree: LVL registered levels. Level k holds N_LANES>>k sums, each W_BITS+k bits wide, zero-extended on add, with no truncation.
- in_valid and in_last travel through a valid/last shift chain alongside the data.
- total_sum and sum_valid appear LVL cycles after the accepting edge (8 at defaults).
- A cycle with in_valid=0 is a bubble. It propagates as an invalid slot, and data registers may hold stale values.
- Accumulator stage (+1 cycle): on a tree slot with valid=1:
  - if frame-start flag=1: acc <= zext(total_sum) and cnt <= 1
  - else: acc <= acc + zext(total_sum) and cnt <= cnt + 1
  - frame-start flag <= last
- On a valid slot with last=1, the following are registered on the same edge:
  - Q <= the new acc value
  - beat_cnt <= the new cnt
  - out_valid pulses high for one cycle
- Latency from an in_last beat to out_valid is LVL+1 cycles (9 at defaults). A single-beat frame (in_valid=in_last=1) is legal.
- Back-to-back frames need no gap: a frame's first beat may directly follow the previous frame's last beat.
- Invalid slots leave acc, cnt and the flag unchanged, so bubbles inside a frame are allowed.
- cnt saturates at 2^CNT_W-1. acc width behaviour is set by the Optional Feature.
- in_last with in_valid=0 is ignored.
- ovf is cleared only by reset.

Optional Feature:
Macro MAC_ACC_SAT_EN
- Defined: an accumulation whose true sum exceeds 2^ACC_W-1 clamps acc to 2^ACC_W-1 and sets ovf. Later adds in that frame stay clamped.
- Undefined: acc wraps modulo 2^ACC_W and ovf is still set on the carry-out.
- Both builds: ovf is sticky.

Test Plan:
1. Defaults, in_array all ones, all weights 15, single beat with in_last -> total_sum=3840 with sum_valid 8 cycles later; out_valid 9 cycles later with Q=3840 and beat_cnt=1.
2. Three consecutive beats of stimulus 1, last on beat 3 -> three sum_valid pulses; one out_valid with Q=11520 and beat_cnt=3; ovf=0.
3. Frame A (1 beat, Q=3840) followed next cycle by frame B (2 beats, in_array=0x…0F with lanes 0-3 active, weights 15) -> out_valid with Q=3840, then two cycles later Q=120 and beat_cnt=2.
4. 2-beat frame of stimulus 1 with 3 idle cycles between beats -> Q=7680 and beat_cnt=2; no sum_valid during the bubbles.
5. ACC_W=13, stimulus-1 frame of 3 beats -> with MAC_ACC_SAT_EN: Q=8191, ovf=1; without: Q=11520 mod 8192=3328, ovf=1.
6. Reset asserted 4 cycles into a 2-beat frame, then a fresh 1-beat frame of stimulus 1 -> no out_valid from the aborted frame; all outputs 0 during reset; fresh frame gives Q=3840 and beat_cnt=1.

Source files
------------

// File: rtl/mac_accum_tree.sv
// Binary-activation MAC: gated weights reduced by a registered adder tree, then accumulated per frame.
// Optional MAC_ACC_SAT_EN: clamp the frame accumulator at its maximum instead of wrapping.
module mac_accum_tree #(
    parameter int N_LANES = 256,
    parameter int W_BITS  = 4,
    parameter int ACC_W   = 20,
    parameter int CNT_W   = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    input  logic [N_LANES-1:0]                   in_array,
    input  logic [N_LANES*W_BITS-1:0]            weight_array,
    output logic                                 sum_valid,
    output logic [W_BITS+$clog2(N_LANES)-1:0]    total_sum,
    output logic                                 out_valid,
    output logic [ACC_W-1:0]                     Q,
    output logic [CNT_W-1:0]                     beat_cnt,
    output logic                                 ovf
);
    localparam int LVL   = $clog2(N_LANES);
    localparam int SUM_W = W_BITS + LVL;
    localparam int PAD   = ACC_W + 1 - SUM_W;

    // Handshake: a beat is accepted on every rising edge with in_valid=1 (no backpressure);
    // sum_valid and out_valid are single-cycle pulses with no ready, consumers must take them.

    logic [W_BITS-1:0] prod [N_LANES];

    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            prod[i] = in_array[i] ? weight_array[i*W_BITS +: W_BITS] : '0;
        end
    end

    // Level k holds N_LANES>>k partial sums, each one bit wider than the level below.
    for (genvar k = 1; k <= LVL; k++) begin : g_lvl
        localparam int NK = N_LANES >> k;
        localparam int WK = W_BITS + k;
        logic [WK-1:0] sum_d [NK];
        logic [WK-1:0] sum_q [NK];

        if (k == 1) begin : g_leaf
            always_comb begin
                for (int j = 0; j < NK; j++) begin
                    sum_d[j] = {1'b0, prod[2*j]} + {1'b0, prod[2*j+1]};
                end
            end
        end else begin : g_node
            always_comb begin
                for (int j = 0; j < NK; j++) begin
                    sum_d[j] = {1'b0, g_lvl[k-1].sum_q[2*j]} + {1'b0, g_lvl[k-1].sum_q[2*j+1]};
                end
            end
        end

        always_ff @(posedge clk) begin
            for (int j = 0; j < NK; j++) begin
                if (reset && (k == LVL)) begin
                    sum_q[j] <= '0;
                end else begin
                    sum_q[j] <= sum_d[j];
                end
            end
        end
    end

    logic [LVL:1] vld_d, vld_q;
    logic [LVL:1] lst_d, lst_q;

    always_comb begin
        vld_d[1] = in_valid;
        lst_d[1] = in_valid & in_last;
        for (int k = 2; k <= LVL; k++) begin
            vld_d[k] = vld_q[k-1];
            lst_d[k] = lst_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= vld_d;
            lst_q <= lst_d;
        end
    end

    logic             slot_vld, slot_lst;
    logic [ACC_W-1:0] acc_d, acc_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             first_d, first_q;
    logic [ACC_W-1:0] q_d, q_q;
    logic [CNT_W-1:0] beat_cnt_d, beat_cnt_q;
    logic             out_valid_d, out_valid_q;
    logic             ovf_d, ovf_q;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   acc_sum;

    assign slot_vld = vld_q[LVL];
    assign slot_lst = lst_q[LVL];

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        q_d         = q_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = 1'b0;
        ovf_d       = ovf_q;
        acc_base    = first_q ? '0 : acc_q;
        acc_sum     = {1'b0, acc_base} + {{PAD{1'b0}}, total_sum};
        if (slot_vld) begin
            // acc_sum[ACC_W] is the carry-out past the accumulator range.
`ifdef MAC_ACC_SAT_EN
            acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`else
            acc_d = acc_sum[ACC_W-1:0];
`endif
            ovf_d   = ovf_q | acc_sum[ACC_W];
            if (first_q) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            first_d = slot_lst;
            if (slot_lst) begin
                q_d         = acc_d;
                beat_cnt_d  = cnt_d;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            q_q         <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            q_q         <= q_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign sum_valid = vld_q[LVL];
    assign total_sum = g_lvl[LVL].sum_q[0];
    assign out_valid = out_valid_q;
    assign Q         = q_q;
    assign beat_cnt  = beat_cnt_q;
    assign ovf       = ovf_q;

endmodule
